// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit nibble per clock, LS nibble first.
// Each nibble is computed for both carry-in values and the registered carry
// from the previous nibble picks the result (carry-select).
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] a_nib, b_nib;
  logic [4:0] s0, s1, s;
  logic       c3;

  // Current nibble slice and both carry-select candidates.
  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4];
  assign s0    = {1'b0, a_nib} + {1'b0, b_nib};
  assign s1    = s0 + 5'd1;
  assign s     = cr_q ? s1 : s0;
  // Carry into bit 3 of the nibble, recovered from the sum bit.
  assign c3    = a_nib[3] ^ b_nib[3] ^ s[3];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cr_d    = cr_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cr_d    = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d[{idx_q, 2'b00} +: 4] = s[3:0];
        cr_d = s[4];
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = s[4];
          ovf_d   = c3 ^ s[4];
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cr_q    <= cr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder at WIDTH=16 and 32.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cin;
  logic [15:0] a, b;
  logic [31:0] a32, b32;

  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a32),
    .b     (b32),
    .cin   (cin),
    .busy  (busy32),
    .done  (done32),
    .sum   (sum32),
    .cout  (cout32),
    .ovf   (ovf32)
  );

  // Called at a falling edge; returns one falling edge after the accepting edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin);
    a     = ia;
    b     = ib;
    cin   = icin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done on the 16-bit DUT; cyc=20 means it never came.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    cin   = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    a32   = 32'h0;
    b32   = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
  endtask

  // Also covers acceptance on the very first edge after reset release.
  task automatic test_basic;
    int cyc;
    issue(16'h1234, 16'h4321, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", done); end
    wait_done(cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    checks++; if (sum !== 16'h5555) begin failures++; $display("FAIL basic_sum got=%h exp=5555", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (sum !== 16'h5555) begin failures++; $display("FAIL basic_sum_hold got=%h exp=5555", sum); end
  endtask

  task automatic test_carry_ripple;
    int cyc;
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL ripple_latency got=%0d exp=4", cyc); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL ripple_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b exp=1", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ripple_ovf got=%b exp=0", ovf); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int cyc;
    issue(16'h7FFF, 16'h0000, 1'b1);
    wait_done(cyc);
    checks++; if (sum !== 16'h8000) begin failures++; $display("FAIL ovf1_sum got=%h exp=8000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL ovf1_cout got=%b exp=0", cout); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf1_ovf got=%b exp=1", ovf); end
    @(negedge clk);
    issue(16'h8000, 16'h8000, 1'b0);
    wait_done(cyc);
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL ovf2_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL ovf2_cout got=%b exp=1", cout); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf2_ovf got=%b exp=1", ovf); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(16'h00F0, 16'h0010, 1'b0);
    // Start pulse with different operands while busy must be ignored.
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
    checks++; if (sum !== 16'h0100) begin failures++; $display("FAIL ign_sum got=%h exp=0100", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL ign_cout got=%b exp=0", cout); end
    // Start in the DONE cycle is accepted.
    issue(16'h0001, 16'h0001, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0001) begin end
    checks--;
    wait_done(cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", cyc); end
    checks++; if (sum !== 16'h0002) begin failures++; $display("FAIL b2b_sum got=%h exp=0002", sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    issue(16'h1234, 16'h4321, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (sum !== 16'h0055) begin failures++; $display("FAIL mid_partial got=%h exp=0055", sum); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0) begin failures++; $display("FAIL mid_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL mid_cout got=%b exp=0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'hAAAA, 16'h5555, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL post_latency got=%0d exp=4", cyc); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL post_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL post_cout got=%b exp=1", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL post_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_random;
    logic [31:0] r;
    logic [16:0] e16;
    logic [32:0] e32;
    logic        eo16, eo32;
    int          cyc;
    // Let the 32-bit instance finish anything left from directed tests.
    repeat (12) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      r   = $urandom; a = r[15:0]; b = r[31:16];
      a32 = $urandom; b32 = $urandom;
      r   = $urandom; cin = r[0];
      e16  = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      eo16 = (a[15] == b[15]) && (e16[15] != a[15]);
      e32  = {1'b0, a32} + {1'b0, b32} + {32'h0, cin};
      eo32 = (a32[31] == b32[31]) && (e32[31] != a32[31]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      checks++;
      if (done !== 1'b1 || {cout, sum} !== e16 || ovf !== eo16) begin
        failures++;
        $display("FAIL rand16 a=%h b=%h cin=%b got=%b_%h/%b exp=%b_%h/%b",
                 a, b, cin, cout, sum, ovf, e16[16], e16[15:0], eo16);
      end
      cyc = 0;
      while (done32 !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (done32 !== 1'b1 || {cout32, sum32} !== e32 || ovf32 !== eo32) begin
        failures++;
        $display("FAIL rand32 a=%h b=%h cin=%b got=%b_%h/%b exp=%b_%h/%b",
                 a32, b32, cin, cout32, sum32, ovf32, e32[32], e32[31:0], eo32);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
